// File: rtl/key_pkg.sv
// Shared definitions for the key input conditioner.
// Holds the per-key FSM state encoding, default timing constants and the
// key index map used by the mode/set logic.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } key_state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_DEBOUNCE_TICKS = 4;
    localparam int DEF_REPEAT_DELAY   = 16;
    localparam int DEF_REPEAT_RATE    = 4;

    localparam int KEY_MODE = 0;
    localparam int KEY_ADD  = 1;

    // Width that holds the largest tick count any counter must reach.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_input_conditioner_if.sv
// Key bus between the raw button pins / tick source and the conditioner.
//   tick        : one-cycle timing strobe from the display/clock counter
//   key_raw     : raw asynchronous key levels
//   key_level   : debounced pressed level (1 = pressed)
//   key_down    : one-cycle pulse on accepted press
//   key_up      : one-cycle pulse on accepted release
//   key_repeat  : one-cycle pulse per auto-repeat while held
//   key_event   : key_down | key_repeat
// master = stimulus side (drives tick/key_raw), slave = conditioner.
interface key_input_conditioner_if #(
    parameter int NUM_KEYS = 2
);
    logic                tick;
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_down;
    logic [NUM_KEYS-1:0] key_up;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] key_event;

    modport master (
        output tick, key_raw,
        input  key_level, key_down, key_up, key_repeat, key_event
    );

    modport slave (
        input  tick, key_raw,
        output key_level, key_down, key_up, key_repeat, key_event
    );
endinterface

// File: rtl/key_debounce_fsm.sv
// Single-key conditioner: synchroniser, debounce/repeat FSM, counters and
// registered event outputs.
//   clock, reset  : system clock, asynchronous active-low reset
//   tick_i        : timing strobe; all debounce/repeat timing counts ticks
//   key_raw_i     : raw asynchronous key level
//   key_level_o   : debounced pressed level
//   key_down_o    : one-cycle pulse on accepted press
//   key_up_o      : one-cycle pulse on accepted release
//   key_repeat_o  : one-cycle pulse per auto-repeat while held
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
    parameter bit ACTIVE_HIGH    = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic key_raw_i,
    output logic key_level_o,
    output logic key_down_o,
    output logic key_up_o,
    output logic key_repeat_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEB_LAST   = cnt_t'(DEBOUNCE_TICKS - 1);
    localparam cnt_t DELAY_LAST = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t RATE_LAST  = cnt_t'(REPEAT_RATE - 1);
    localparam cnt_t CNT_SAT    = '1;
    localparam bit   REPEAT_EN  = (REPEAT_DELAY != 0);
    localparam logic RAW_IDLE   = ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;

    key_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    cnt_t       hold_q, hold_d;
    logic       rate_q, rate_d;   // 1 once the first repeat fired: count REPEAT_RATE
    logic       level_q, level_d;
    logic       down_q, down_d;
    logic       up_q, up_d;
    logic       rep_q, rep_d;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_SAT) ? v : v + cnt_t'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    // The synchroniser resets to the released level so a key held through
    // reset is seen as a fresh press once reset lifts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= {SYNC_STAGES{RAW_IDLE}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_i};
    end

    assign pressed = ACTIVE_HIGH ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rate_d  = rate_q;
        level_d = level_q;
        down_d  = 1'b0;
        up_d    = 1'b0;
        rep_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_DEB;
                    cnt_d   = '0;
                end
            end
            PRESS_DEB: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (tick_i) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        down_d  = 1'b1;
                        hold_d  = '0;
                        rate_d  = 1'b0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            HELD: begin
                // hold_q/rate_q are left untouched on release so a bounce-back
                // resumes the repeat cadence where it stopped.
                if (!pressed) begin
                    state_d = RELEASE_DEB;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (REPEAT_EN && hold_q == (rate_q ? RATE_LAST : DELAY_LAST)) begin
                        rep_d  = 1'b1;
                        hold_d = '0;
                        rate_d = 1'b1;
                    end else begin
                        hold_d = sat_inc(hold_q);
                    end
                end
            end
            RELEASE_DEB: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (tick_i) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        up_d    = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            rate_q  <= 1'b0;
            level_q <= 1'b0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rate_q  <= rate_d;
            level_q <= level_d;
            down_q  <= down_d;
            up_q    <= up_d;
            rep_q   <= rep_d;
        end
    end

    assign key_level_o  = level_q;
    assign key_down_o   = down_q;
    assign key_up_o     = up_q;
    assign key_repeat_o = rep_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Key input conditioner: turns raw push-button levels into clean per-key
// press/release/repeat strobes for the mode/set state machine.
//   clock, reset : system clock, asynchronous active-low reset
//   kif (slave)  : tick and key_raw in; key_level, key_down, key_up,
//                  key_repeat and key_event (down | repeat) out
module key_input_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS       = 2,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
    parameter bit ACTIVE_HIGH    = 1'b1
) (
    input logic                    clock,
    input logic                    reset,
    key_input_conditioner_if.slave kif
);

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] down;
    logic [NUM_KEYS-1:0] up;
    logic [NUM_KEYS-1:0] rep;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_fsm #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE),
            .ACTIVE_HIGH   (ACTIVE_HIGH)
        ) u_fsm (
            .clock       (clock),
            .reset       (reset),
            .tick_i      (kif.tick),
            .key_raw_i   (kif.key_raw[g]),
            .key_level_o (level[g]),
            .key_down_o  (down[g]),
            .key_up_o    (up[g]),
            .key_repeat_o(rep[g])
        );
    end

    assign kif.key_level  = level;
    assign kif.key_down   = down;
    assign kif.key_up     = up;
    assign kif.key_repeat = rep;
    assign kif.key_event  = down | rep;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: DEBOUNCE_TICKS=4, REPEAT_RATE=2, tick every
// 8 clocks. dut_a uses REPEAT_DELAY=8, dut_b REPEAT_DELAY=0; both see the same
// stimulus. Pulses are counted per step and compared against hand-derived
// totals; raw levels change right after a tick edge.
module tb_key_input_conditioner;

    logic clock;
    logic reset;

    key_input_conditioner_if #(.NUM_KEYS(2)) kif_a ();
    key_input_conditioner_if #(.NUM_KEYS(2)) kif_b ();

    key_input_conditioner #(
        .NUM_KEYS(2), .SYNC_STAGES(2), .DEBOUNCE_TICKS(4),
        .REPEAT_DELAY(8), .REPEAT_RATE(2), .ACTIVE_HIGH(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .kif(kif_a)
    );

    key_input_conditioner #(
        .NUM_KEYS(2), .SYNC_STAGES(2), .DEBOUNCE_TICKS(4),
        .REPEAT_DELAY(0), .REPEAT_RATE(2), .ACTIVE_HIGH(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .kif(kif_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] raw = 2'b00;
    logic [2:0] phase = 3'd0;
    bit         last_tick;

    int down_n [2][2];
    int up_n   [2][2];
    int rep_n  [2][2];
    int evt_n  [2][2];
    bit both_down [2];
    bit level0_seen [2];
    int stray_n   = 0;
    int overlap_n = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                down_n[d][k] = 0;
                up_n[d][k]   = 0;
                rep_n[d][k]  = 0;
                evt_n[d][k]  = 0;
            end
            both_down[d]   = 1'b0;
            level0_seen[d] = 1'b0;
        end
    endtask

    task automatic sample(input int d, input logic [1:0] lv, input logic [1:0] dn,
                          input logic [1:0] upv, input logic [1:0] rp,
                          input logic [1:0] ev, input bit t);
        for (int k = 0; k < 2; k++) begin
            if (dn[k])  down_n[d][k]++;
            if (upv[k]) up_n[d][k]++;
            if (rp[k])  rep_n[d][k]++;
            if (ev[k])  evt_n[d][k]++;
        end
        if (!t && (dn | upv | rp | ev) != 2'b00) stray_n++;
        if ((dn & rp) != 2'b00) overlap_n++;
        if (dn == 2'b11) both_down[d] = 1'b1;
        if (lv[0]) level0_seen[d] = 1'b1;
    endtask

    // One clock: apply inputs, take the edge, sample outputs 1 time unit later.
    task automatic step();
        bit t;
        t = (phase == 3'd7);
        phase = phase + 3'd1;
        kif_a.tick = t;
        kif_b.tick = t;
        kif_a.key_raw = raw;
        kif_b.key_raw = raw;
        @(posedge clock);
        #1;
        last_tick = t;
        sample(0, kif_a.key_level, kif_a.key_down, kif_a.key_up, kif_a.key_repeat, kif_a.key_event, t);
        sample(1, kif_b.key_level, kif_b.key_down, kif_b.key_up, kif_b.key_repeat, kif_b.key_event, t);
    endtask

    task automatic run_ticks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            step();
            if (last_tick) seen++;
        end
    endtask

    task automatic align();
        step();
        while (!last_tick) step();
    endtask

    function automatic int all_outputs();
        return int'({kif_a.key_level, kif_a.key_down, kif_a.key_up, kif_a.key_repeat, kif_a.key_event,
                     kif_b.key_level, kif_b.key_down, kif_b.key_up, kif_b.key_repeat, kif_b.key_event});
    endfunction

    typedef struct {
        string      name;
        logic [1:0] raw;
        int         ticks;
        logic [1:0] level;
        int d0, d1, u0, u1, r0, r1, e0, e1;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [1:0] r, input int t,
                                input logic [1:0] lv, input int d0, input int d1,
                                input int u0, input int u1, input int r0, input int r1,
                                input int e0, input int e1);
        vec_t v;
        v.name = name; v.raw = r; v.ticks = t; v.level = lv;
        v.d0 = d0; v.d1 = d1; v.u0 = u0; v.u1 = u1;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    vec_t vecs [13];

    initial begin
        //             name             raw   tk lvl    d0 d1 u0 u1 r0 r1 e0 e1
        vecs[0]  = mk("k0_press_deb",   2'b01, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk("k0_press",       2'b01, 1, 2'b01, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk("k0_hold",        2'b01, 3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk("k0_rel_deb",     2'b00, 3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk("k0_release",     2'b00, 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk("k1_press_deb",   2'b10, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk("k1_press",       2'b10, 1, 2'b10, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk("k1_first_rep",   2'b10, 8, 2'b10, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[8]  = mk("k1_rate_rep",    2'b10, 8, 2'b10, 0, 0, 0, 0, 0, 4, 0, 4);
        vecs[9]  = mk("k1_bounce_rel",  2'b00, 2, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk("k1_repress",     2'b10, 4, 2'b10, 0, 0, 0, 0, 0, 2, 0, 2);
        vecs[11] = mk("k1_rel_deb",     2'b00, 3, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk("k1_release",     2'b00, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);

        // Reset state.
        reset = 1'b0;
        clear_counts();
        for (int i = 0; i < 3; i++) step();
        check("reset_outputs", all_outputs(), 0);
        align();
        reset = 1'b1;

        // Directed vector table on dut_a.
        for (int i = 0; i < 13; i++) begin
            clear_counts();
            raw = vecs[i].raw;
            run_ticks(vecs[i].ticks);
            check({vecs[i].name, "_level"},  int'(kif_a.key_level), int'(vecs[i].level));
            check({vecs[i].name, "_down0"},  down_n[0][0], vecs[i].d0);
            check({vecs[i].name, "_down1"},  down_n[0][1], vecs[i].d1);
            check({vecs[i].name, "_up0"},    up_n[0][0],   vecs[i].u0);
            check({vecs[i].name, "_up1"},    up_n[0][1],   vecs[i].u1);
            check({vecs[i].name, "_rep0"},   rep_n[0][0],  vecs[i].r0);
            check({vecs[i].name, "_rep1"},   rep_n[0][1],  vecs[i].r1);
            check({vecs[i].name, "_event0"}, evt_n[0][0],  vecs[i].e0);
            check({vecs[i].name, "_event1"}, evt_n[0][1],  vecs[i].e1);
        end

        // Bounce rejection: key0 toggles every 5 clocks for 60 clocks.
        clear_counts();
        for (int i = 0; i < 60; i++) begin
            raw = {1'b0, ((i / 5) % 2) == 0};
            step();
        end
        raw = 2'b00;
        run_ticks(5);
        check("bounce_down0", down_n[0][0], 0);
        check("bounce_up0", up_n[0][0], 0);
        check("bounce_level0_seen", int'(level0_seen[0]), 0);

        // Reset in the middle of a hold, key kept pressed through reset.
        raw = 2'b01;
        run_ticks(6);
        check("midhold_level_before_reset", int'(kif_a.key_level), 1);
        reset = 1'b0;
        #1;
        check("midhold_async_reset_outputs", all_outputs(), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("midhold_reset_cycle%0d_outputs", i), all_outputs(), 0);
        end
        reset = 1'b1;
        clear_counts();
        run_ticks(3);
        check("after_reset_3ticks_down0", down_n[0][0], 0);
        check("after_reset_3ticks_level", int'(kif_a.key_level), 0);
        run_ticks(1);
        check("after_reset_4th_tick_down0", down_n[0][0], 1);
        check("after_reset_4th_tick_level", int'(kif_a.key_level), 1);
        raw = 2'b00;
        clear_counts();
        run_ticks(4);
        check("after_reset_release_up0", up_n[0][0], 1);
        check("after_reset_release_level", int'(kif_a.key_level), 0);

        // Simultaneous press of both keys; dut_b has repeat disabled.
        clear_counts();
        raw = 2'b11;
        run_ticks(4);
        check("simul_a_down0", down_n[0][0], 1);
        check("simul_a_down1", down_n[0][1], 1);
        check("simul_a_both_same_cycle", int'(both_down[0]), 1);
        check("simul_b_both_same_cycle", int'(both_down[1]), 1);
        check("simul_b_level", int'(kif_b.key_level), 3);
        clear_counts();
        run_ticks(30);
        check("norep_b_rep0", rep_n[1][0], 0);
        check("norep_b_rep1", rep_n[1][1], 0);
        check("norep_b_event0", evt_n[1][0], 0);
        check("norep_b_event1", evt_n[1][1], 0);
        check("hold30_a_rep0", rep_n[0][0], 12);
        check("hold30_a_rep1", rep_n[0][1], 12);
        clear_counts();
        raw = 2'b00;
        run_ticks(4);
        check("simul_b_up0", up_n[1][0], 1);
        check("simul_b_up1", up_n[1][1], 1);
        check("simul_b_level_released", int'(kif_b.key_level), 0);

        // Pulses only on tick edges (so exactly one cycle wide), never down+repeat together.
        check("pulses_off_tick_edge", stray_n, 0);
        check("down_repeat_overlap", overlap_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Input-side counterpart to the multiplexed 7-segment display path: turns raw push-button levels (mode, add, ...) into clean per-key event strobes for the clock's mode/set state machine.
- Per key: synchronises the raw level, debounces it on a slow tick, and emits one-cycle press, release and auto-repeat pulses.
- Sits between the raw key inputs and the mode/set logic. Its tick comes from the free-running display/clock counter.

Parameters:
- NUM_KEYS, 2, number of independent keys
- SYNC_STAGES, 2, flip-flop synchroniser depth (min 2)
- DEBOUNCE_TICKS, 4, consecutive ticks a new level must hold before it is accepted (min 1)
- REPEAT_DELAY, 16, ticks from accepted press to first repeat pulse; 0 disables repeat
- REPEAT_RATE, 4, ticks between subsequent repeat pulses (min 1)
- ACTIVE_HIGH, 1, 1: key pressed = raw 1; 0: pressed = raw 0

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle strobe; all debounce/repeat timing counts ticks
- key_raw  in  NUM_KEYS  raw asynchronous key levels
- key_level  out  NUM_KEYS  debounced pressed level (1 = pressed)
- key_down  out  NUM_KEYS  one-cycle pulse on accepted press
- key_up  out  NUM_KEYS  one-cycle pulse on accepted release
- key_repeat  out  NUM_KEYS  one-cycle pulse per auto-repeat while held
- key_event  out  NUM_KEYS  key_down OR key_repeat (use directly as the "add" strobe)

Behaviour:
- Reset is asynchronous and active-low. While reset is 0, all of the following are 0: outputs, synchroniser flops, counters. Every key FSM is IDLE.
- The synchroniser flops reset to the inactive level, so a key held through reset is not a press at reset. It is detected normally after DEBOUNCE_TICKS.
- Synchroniser: SYNC_STAGES flops on clock, then polarity normalisation, giving p (1 = pressed).
- Per-key FSM states:
  - IDLE: level 0. p=1 → PRESS_DEB, counter cleared.
  - PRESS_DEB: on each tick with p=1, cnt++. If p=0 in any cycle → IDLE, no pulse.
    - When a tick arrives with cnt==DEBOUNCE_TICKS-1 and p=1 → HELD.
    - On that transition: key_level=1 and key_down=1 in the next cycle. hold_cnt is cleared.
  - HELD: on each tick, hold_cnt++.
    - If REPEAT_DELAY≠0 and a tick arrives with hold_cnt==REPEAT_DELAY-1 → key_repeat pulse. hold_cnt then reloads to count REPEAT_RATE.
    - Each further REPEAT_RATE ticks → one more key_repeat pulse.
    - p=0 → RELEASE_DEB, cnt cleared; hold_cnt frozen.
  - RELEASE_DEB: on each tick with p=0, cnt++.
    - If p=1 in any cycle → back to HELD with hold_cnt resumed. No key_up; key_level stays 1.
    - When a tick arrives with cnt==DEBOUNCE_TICKS-1 and p=0 → IDLE. key_level=0 and key_up=1 in the next cycle.
- Outputs are registered, so latency is exactly 1 clock after the qualifying tick edge.
- Each pulse is exactly one cycle, even if tick is held high continuously.
- Repeat pulses are never emitted in RELEASE_DEB.
- key_down and key_repeat are never asserted in the same cycle for the same key.
- Ticks with no state change have no effect. Cycles without a tick only react to bounce-back (the p reversals described above).
- Keys are fully independent. Simultaneous presses produce simultaneous pulses on both bits.
- Counter widths: $clog2 of max(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE)+1. Counters saturate and never wrap.
- The first accepted event after reset is a press.

Decomposition:
- Shared package key_pkg holds:
  - the FSM state encoding (IDLE, PRESS_DEB, HELD, RELEASE_DEB; 2-bit);
  - default constants for the debounce/repeat tick counts;
  - key index constants KEY_MODE=0, KEY_ADD=1.
- Sub-module key_debounce_fsm: single key, covering synchroniser, FSM, counters and output registers. The top level instantiates it NUM_KEYS times via generate and ORs key_event.

Test Plan (bench: DEBOUNCE_TICKS=4, REPEAT_DELAY=8, REPEAT_RATE=2, tick every 8 clocks):
- Reset mid-hold: hold key0 pressed and pulse reset low for 3 cycles mid-HELD → all outputs 0 during reset; key_down[0] re-fires 1 clock after the 4th tick following release of reset.
- Clean press: key_raw[0]=1 held → key_down[0] high for exactly 1 cycle, 1 clock after the 4th tick; key_level[0]=1 from then; no other pulses.
- Bounce rejection: toggle key_raw[0] every 5 clocks for 60 clocks → zero key_down/key_up pulses; key_level[0] stays 0.
- Auto-repeat: hold key1 for 20 ticks → key_down[1] after tick 4, key_repeat[1] after ticks 12, 14, 16, 18, 20 (5 pulses); key_event[1] shows 6 pulses total.
- Release with bounce-back: release key1 at 2 ticks, re-press within tick 3 of release → no key_up, key_level stays 1, repeat resumes. Final release → key_up[1] 1 clock after the 4th tick.
- Simultaneous keys: press key0 and key1 in the same cycle → key_down=2'b11 in a single cycle. With REPEAT_DELAY=0, hold 30 ticks → no key_repeat.
